nibble_rev_serializer: RTL and testbench

- Design-side endpoint of the nibble-in / serial-bit-out interface.
- Captures a burst of 4-bit nibbles presented under in_valid, buffers them, then replays them in reverse arrival order as a 1-bit serial stream under out_valid.
- Each nibble is sent MSB first.
- Sits directly on the pattern interface, with the same port names and polarities the bench drives and samples.

---
 rtl/nibble_ser_pkg.sv | 27 ++
 rtl/nibble_lifo_buf.sv | 33 +++
 rtl/nibble_rev_serializer.sv | 168 ++++++++++++++++
 tb/tb_nibble_rev_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/nibble_ser_pkg.sv
// Shared types and constants for the nibble reverse serializer.
//   state_t   : controller states (PAR only reachable with parity enabled)
//   nib_t     : one 4-bit nibble
//   wr_req_t  : buffer write request {en, idx, data}
package nibble_ser_pkg;

  localparam int NIB_W       = 4;
  localparam int MAX_NIB_DEF = 8;
  // Buffer index width; covers the largest supported depth of 16.
  localparam int IDX_W       = 4;

  typedef logic [NIB_W-1:0] nib_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OUT,
    PAR
  } state_t;

  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] idx;
    nib_t             data;
  } wr_req_t;

endpackage

// File: rtl/nibble_lifo_buf.sv
// DEPTH x 4-bit register file holding one burst of nibbles.
//   clk, rst_n : clock, async active-low clear (all entries to 0)
//   wr         : write request, entry wr.idx takes wr.data when wr.en
//   rd_idx     : read index
//   rd_data    : combinational read of entry rd_idx (0 if out of range)
module nibble_lifo_buf
  import nibble_ser_pkg::*;
#(
  parameter int DEPTH = MAX_NIB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  wr_req_t          wr,
  input  logic [IDX_W-1:0] rd_idx,
  output nib_t             rd_data
);

  nib_t mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                mem[i] <= '0;
      else if (wr.en && wr.idx == IDX_W'(i))     mem[i] <= wr.data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_idx == IDX_W'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/nibble_rev_serializer.sv
// Nibble-in / serial-bit-out endpoint. Captures a contiguous in_valid burst
// of nibbles (up to MAX_NIB, extras dropped), then replays them newest
// first, each nibble MSB first, on result under out_valid.
//   clk       : rising-edge clock
//   rst_n     : async active-low reset, aborts any transfer
//   in_valid  : data carries a nibble (ignored while a stream is running)
//   data      : 4-bit nibble
//   out_valid : result carries a valid bit
//   result    : serial bit, 0 when out_valid=0
// Optional build macro NIBBLE_REV_SERIALIZER_PARITY_EN appends one even
// parity bit (XOR of all emitted data bits) after the last data bit.
module nibble_rev_serializer
  import nibble_ser_pkg::*;
#(
  parameter int MAX_NIB = MAX_NIB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [NIB_W-1:0] data,
  output logic             out_valid,
  output logic             result
);

  localparam int               CNT_W   = $clog2(MAX_NIB + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NIB);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       bit_q, bit_d;
  logic             ovf_q, ovf_d;
  logic             ov_d, res_d;
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  wr_req_t          wr;
  logic [IDX_W-1:0] rd_idx;
  nib_t             rd_data;
  logic [1:0]       nxt_bit;
  logic             last_bit;

  nibble_lifo_buf #(.DEPTH(MAX_NIB)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // (rd_ptr_q, bit_q) names the bit currently on result; the buffer is read
  // at the position of the bit to show next so result stays a flop output.
  // From LOAD that is the MSB of the newest nibble. The 2-bit bit index
  // wraps 0 -> 3 on its own when stepping to the next older nibble.
  assign last_bit = (bit_q == 2'd0) && (rd_ptr_q == '0);
  assign nxt_bit  = (state_q == LOAD) ? 2'd3 : bit_q - 2'd1;

  always_comb begin
    if (state_q == LOAD)       rd_idx = IDX_W'(cnt_q - 1'b1);
    else if (bit_q == 2'd0)    rd_idx = rd_ptr_q - 1'b1;
    else                       rd_idx = rd_ptr_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    bit_d    = bit_q;
    ovf_d    = ovf_q;
    ov_d     = 1'b0;
    res_d    = 1'b0;
    wr       = '0;
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr.en   = 1'b1;
          wr.idx  = '0;
          wr.data = data;
          cnt_d   = CNT_W'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (!ovf_q && cnt_q < MAX_CNT) begin
            wr.en   = 1'b1;
            wr.idx  = IDX_W'(cnt_q);
            wr.data = data;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          rd_ptr_d = rd_idx;
          bit_d    = nxt_bit;
          ov_d     = 1'b1;
          res_d    = rd_data[nxt_bit];
          state_d  = OUT;
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
          par_d    = rd_data[nxt_bit];
`endif
        end
      end
      OUT: begin
        if (last_bit) begin
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
          // par_q already covers every data bit including the one on result.
          ov_d    = 1'b1;
          res_d   = par_q;
          state_d = PAR;
`else
          state_d = IDLE;
`endif
        end else begin
          rd_ptr_d = rd_idx;
          bit_d    = nxt_bit;
          ov_d     = 1'b1;
          res_d    = rd_data[nxt_bit];
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
          par_d    = par_q ^ rd_data[nxt_bit];
`endif
        end
      end
      PAR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Burst bookkeeping is dropped whenever a transfer finishes.
    if (state_d == IDLE && state_q != IDLE) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      bit_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      bit_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      result    <= 1'b0;
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      bit_q     <= bit_d;
      ovf_q     <= ovf_d;
      out_valid <= ov_d;
      result    <= res_d;
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_rev_serializer.sv
// Self-checking bench for nibble_rev_serializer: fixed vector table,
// reset-abort sequence, and randomized bursts against a queue model.
module tb_nibble_rev_serializer;
  import nibble_ser_pkg::*;

  localparam int MAX_NIB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [3:0] data;
  logic out_valid;
  logic result;

  int n_chk = 0;
  int n_err = 0;

  typedef bit bitq_t[$];
  typedef nib_t nibq_t[$];

  typedef struct {
    string       name;
    int          n;
    logic [63:0] nibs;   // nibble i in bits [4i+:4], i=0 arrives first
    bit          pulse;  // assert in_valid during the output stream
    int          len;    // data bits expected
    logic [63:0] exp;    // first emitted bit at exp[len-1]
  } vec_t;

  vec_t tbl[7];

  nibble_rev_serializer #(.MAX_NIB(MAX_NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data      (data),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: keep the first MAX_NIB nibbles, emit newest first, MSB first.
  function automatic bitq_t model(input nibq_t nibs);
    bitq_t q;
    int kept;
    kept = (nibs.size() > MAX_NIB) ? MAX_NIB : nibs.size();
    for (int i = kept - 1; i >= 0; i--)
      for (int b = 3; b >= 0; b--) q.push_back(nibs[i][b]);
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
    begin
      bit p;
      p = 1'b0;
      foreach (q[k]) p ^= q[k];
      q.push_back(p);
    end
`endif
    return q;
  endfunction

  // Called between edges. Drives the burst, checks the one-cycle gap, every
  // output bit, and the fall of out_valid. Returns in the first cycle with
  // out_valid=0, so a following call starts a back-to-back burst.
  task automatic run_stream(input string tag, input nibq_t nibs, input bitq_t exp_q, input bit pulse);
    foreach (nibs[i]) begin
      in_valid = 1'b1;
      data     = nibs[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    data     = 4'($urandom);
    @(negedge clk);
    check({tag, "_gap"}, 32'(out_valid), 32'd0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (pulse && k == 1) begin in_valid = 1'b1; data = 4'($urandom); end
      if (pulse && k == 3) in_valid = 1'b0;
      check($sformatf("%s_v%0d", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s_b%0d", tag, k), 32'(result), 32'(exp_q[k]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_endv"}, 32'(out_valid), 32'd0);
    check({tag, "_endr"}, 32'(result), 32'd0);
  endtask

  initial begin
    nibq_t nq;
    bitq_t eq;

    tbl[0] = '{"a3f",   3,  64'hF3A,        1'b0, 12, 64'hF3A};
    tbl[1] = '{"one9",  1,  64'h9,          1'b0, 4,  64'h9};
    tbl[2] = '{"b2b6",  1,  64'h6,          1'b0, 4,  64'h6};
    tbl[3] = '{"ovf10", 10, 64'h9876543210, 1'b0, 32, 64'h76543210};
    tbl[4] = '{"pulse", 2,  64'hC5,         1'b1, 8,  64'hC5};
    tbl[5] = '{"p71",   2,  64'h17,         1'b0, 8,  64'h17};
    tbl[6] = '{"full8", 8,  64'h87654321,   1'b0, 32, 64'h87654321};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    data     = 4'h0;
    #3;
    check("rst_v", 32'(out_valid), 32'd0);
    check("rst_r", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset after 5 bits of a 3-nibble burst aborts at once, no resume.
    begin
      nib_t rn [3] = '{4'h1, 4'h2, 4'h3};
      foreach (rn[i]) begin
        in_valid = 1'b1; data = rn[i];
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("ra_v%0d", k), 32'(out_valid), 32'd1);
      end
      #1 rst_n = 1'b0;
      #1;
      check("ra_async_v", 32'(out_valid), 32'd0);
      check("ra_async_r", 32'(result), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check($sformatf("ra_idle%0d", k), 32'(out_valid | result), 32'd0);
      end
    end

    // Table vectors, each starting right as the previous stream ends.
    foreach (tbl[i]) begin
      nq.delete(); eq.delete();
      for (int j = 0; j < tbl[i].n; j++) nq.push_back(tbl[i].nibs[4*j +: 4]);
      for (int k = 0; k < tbl[i].len; k++) eq.push_back(tbl[i].exp[tbl[i].len - 1 - k]);
`ifdef NIBBLE_REV_SERIALIZER_PARITY_EN
      begin
        bit p;
        p = 1'b0;
        foreach (eq[k]) p ^= eq[k];
        eq.push_back(p);
      end
`endif
      run_stream(tbl[i].name, nq, eq, tbl[i].pulse);
    end

    // Randomized bursts against the model, with random idle gaps.
    for (int it = 0; it < 30; it++) begin
      int n, gap;
      n   = $urandom_range(1, MAX_NIB + 3);
      gap = $urandom_range(0, 2);
      nq.delete();
      for (int j = 0; j < n; j++) nq.push_back(4'($urandom));
      eq = model(nq);
      run_stream($sformatf("rnd%0d", it), nq, eq, 1'($urandom_range(0, 1)));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check($sformatf("rnd%0d_idle%0d", it, g), 32'(out_valid), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
